// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table sequencer and checker for N_IN-input boolean units
//
// Purpose:
//   Steps dut_in_o through 0 .. 2**N_IN-1 in ascending order.
//   Each value is held for DRIVE + SETTLE_CYCLES + SAMPLE cycles.
//   In SAMPLE the unit output dut_y_i is captured into table_out_o and compared
//   against expected_i. The block counts mismatches and records the first one.
//
// Optional feature (macro SWEEP_STOP_ON_FAIL_EN):
//   When the macro is defined, the first mismatch ends the sweep immediately.
//
// Ports:
//   clk_i              system clock, rising edge
//   rst_i              asynchronous active-high reset
//   start_i            begin a sweep (sampled only while idle)
//   expected_i         golden truth table, bit i = expected y for input value i
//   dut_in_o           function-unit inputs (MSB = a ... LSB = c)
//   dut_y_i            function-unit output
//   busy_o             high in every non-idle state
//   done_o             one-cycle pulse while in DONE
//   table_out_o        captured truth table, bit i = y observed for input i
//   fail_count_o       number of mismatching entries (saturating at 2**N_IN)
//   first_fail_idx_o   lowest mismatching input value (valid when fail_count_o != 0)
//   pass_o             1 iff the last completed sweep had no mismatch
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [2**N_IN-1:0]   expected_i,
  output logic [N_IN-1:0]      dut_in_o,
  input  logic                 dut_y_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2**N_IN-1:0]   table_out_o,
  output logic [N_IN:0]        fail_count_o,
  output logic [N_IN-1:0]      first_fail_idx_o,
  output logic                 pass_o
);

  localparam int              DEPTH       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(DEPTH - 1);
  localparam logic [N_IN:0]   FAIL_MAX    = (N_IN+1)'(DEPTH);
  localparam logic [3:0]      SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [3:0]          settle_q, settle_d;
  logic [N_IN-1:0]     dut_in_q, dut_in_d;
  logic [DEPTH-1:0]    table_q, table_d;
  logic [N_IN:0]       fail_q, fail_d;
  logic [N_IN-1:0]     first_q, first_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                mismatch;

  assign mismatch = (dut_y_i != expected_i[idx_q]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      dut_in_q <= '0;
      table_q  <= '0;
      fail_q   <= '0;
      first_q  <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      dut_in_q <= dut_in_d;
      table_q  <= table_d;
      fail_q   <= fail_d;
      first_q  <= first_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    dut_in_d = dut_in_q;
    table_d  = table_q;
    fail_d   = fail_q;
    first_d  = first_q;
    pass_d   = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_DRIVE;
          idx_d    = '0;
          dut_in_d = '0;
          table_d  = '0;
          fail_d   = '0;
          first_d  = '0;
          pass_d   = 1'b0;
        end
      end

      ST_DRIVE: begin
        // dut_in already carries idx; it was loaded on the edge into DRIVE.
        settle_d = SETTLE_INIT;
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // Counter enters at SETTLE_CYCLES; the cycle that sees 1 is the last one.
        settle_d = (settle_q != 4'd0) ? settle_q - 4'd1 : 4'd0;
        if (settle_q <= 4'd1) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        table_d[idx_q] = dut_y_i;
        if (mismatch) begin
          if (fail_q != FAIL_MAX) begin
            fail_d = fail_q + 1'b1;
          end
          if (fail_q == '0) begin
            first_d = idx_q;
          end
        end
`ifdef SWEEP_STOP_ON_FAIL_EN
        if (mismatch || (idx_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          dut_in_d = idx_q + 1'b1;
          state_d  = ST_DRIVE;
        end
`else
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          dut_in_d = idx_q + 1'b1;
          state_d  = ST_DRIVE;
        end
`endif
      end

      ST_DONE: begin
        pass_d  = (fail_q == '0);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the state being entered.
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  assign dut_in_o         = dut_in_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign table_out_o      = table_q;
  assign fail_count_o     = fail_q;
  assign first_fail_idx_o = first_q;
  assign pass_o           = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default settle (2). Instance B: settle 0.
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] exp_a = 8'h00, exp_b = 8'h00;
  logic [7:0] func_a = 8'h00, func_b = 8'h00;
  logic [2:0] dut_in_a, dut_in_b;
  logic       y_a, y_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] tbl_a, tbl_b;
  logic [3:0] fcnt_a, fcnt_b;
  logic [2:0] first_a, first_b;

  // Behavioural function units: a lookup into the unit's truth table.
  assign y_a = func_a[dut_in_a];
  assign y_b = func_b[dut_in_b];

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .expected_i(exp_a),
    .dut_in_o(dut_in_a), .dut_y_i(y_a), .busy_o(busy_a), .done_o(done_a),
    .table_out_o(tbl_a), .fail_count_o(fcnt_a), .first_fail_idx_o(first_a),
    .pass_o(pass_a)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .expected_i(exp_b),
    .dut_in_o(dut_in_b), .dut_y_i(y_b), .busy_o(busy_b), .done_o(done_b),
    .table_out_o(tbl_b), .fail_count_o(fcnt_b), .first_fail_idx_o(first_b),
    .pass_o(pass_b)
  );

  logic       cur_sel = 1'b0;
  logic [2:0] m_in;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_tbl;
  logic [3:0] m_fcnt;
  logic [2:0] m_first;
  assign m_in    = cur_sel ? dut_in_b : dut_in_a;
  assign m_busy  = cur_sel ? busy_b   : busy_a;
  assign m_done  = cur_sel ? done_b   : done_a;
  assign m_pass  = cur_sel ? pass_b   : pass_a;
  assign m_tbl   = cur_sel ? tbl_b    : tbl_a;
  assign m_fcnt  = cur_sel ? fcnt_b   : fcnt_a;
  assign m_first = cur_sel ? first_b  : first_a;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Reference: what a sweep of unit f against expected e must produce.
  task automatic model(input logic [7:0] f, input logic [7:0] e, input int s,
                       output logic [7:0] tbl, output int cnt, output int first,
                       output int lat, output int last, output bit pas);
    logic [7:0] mism;
    bit found;
    int n;
    mism = f ^ e;
    found = 1'b0;
    cnt = 0;
    first = 0;
    for (int i = 0; i < 8; i++) begin
      if (mism[i]) begin
        if (!found) first = i;
        found = 1'b1;
        cnt++;
      end
    end
    n = 8;
    if (STOP && found) begin
      n = first + 1;
      cnt = 1;
    end
    tbl = 8'h00;
    for (int i = 0; i < n; i++) tbl[i] = f[i];
    lat = (2 + s) * n;
    last = n - 1;
    pas = !found;
  endtask

  task automatic run_sweep(input logic sel, input logic [7:0] f, input logic [7:0] e);
    logic [7:0] w_tbl;
    int w_cnt, w_first, w_lat, w_last, s, done_at, traj_bad;
    bit w_pass;
    s = sel ? 0 : 2;
    model(f, e, s, w_tbl, w_cnt, w_first, w_lat, w_last, w_pass);
    cur_sel = sel;
    @(negedge clk);
    if (sel) begin func_b = f; exp_b = e; start_b = 1'b1; end
    else     begin func_a = f; exp_a = e; start_a = 1'b1; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    done_at = -1;
    traj_bad = 0;
    for (int j = 0; j < 200; j++) begin
      if (m_done) begin
        done_at = j;
        break;
      end
      if (m_in !== 3'(j / (2 + s)) || m_busy !== 1'b1) traj_bad++;
      @(posedge clk);
      #1;
    end
    check("done_latency", done_at, w_lat);
    check("dut_in_trajectory_errors", traj_bad, 0);
    check("busy_in_done", m_busy, 1);
    check("table_out", m_tbl, w_tbl);
    check("fail_count", m_fcnt, w_cnt);
    if (w_cnt != 0) check("first_fail_idx", m_first, w_first);
    check("dut_in_final", m_in, w_last);
    @(posedge clk);
    #1;
    check("done_one_cycle", m_done, 0);
    check("busy_after_done", m_busy, 0);
    check("pass", m_pass, w_pass);
    check("dut_in_hold", m_in, w_last);
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] f;
    logic [7:0] e;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int done_pulses, done_at, idle_busy, k;
    logic [7:0] f5;

    vecs[0] = '{sel: 1'b0, f: 8'hE8, e: 8'hE8};          // majority, correct
    vecs[1] = '{sel: 1'b0, f: 8'hE8 ^ 8'h28, e: 8'hE8};  // inverted at 3 and 5
    vecs[2] = '{sel: 1'b1, f: 8'h96, e: 8'h96};          // XOR3, no settle
    vecs[3] = '{sel: 1'b0, f: 8'h00, e: 8'hFF};          // all-zero unit

    // Reset values, asserted from time 0.
    #2;
    check("rst_dut_in", dut_in_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_table", tbl_a, 0);
    check("rst_fail", fcnt_a, 0);
    check("rst_first", first_a, 0);
    check("rst_pass", pass_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy_no_start", busy_a, 0);

    for (int v = 0; v < 4; v++) run_sweep(vecs[v].sel, vecs[v].f, vecs[v].e);

    // Randomised units and expectations on both instances.
    for (int r = 0; r < 10; r++) begin
      logic [7:0] rf, re;
      rf = 8'($urandom);
      re = (r % 3 == 0) ? rf : 8'($urandom);
      run_sweep(1'(r % 2), rf, re);
    end

    // Start pulsed mid-sweep is ignored; one done pulse at 32.
    cur_sel = 1'b0;
    @(negedge clk);
    func_a = 8'hE8; exp_a = 8'hE8; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    done_pulses = 0;
    done_at = -1;
    for (int j = 1; j <= 33; j++) begin
      @(posedge clk);
      #1;
      if (j == 10) start_a = 1'b1;
      if (j == 11) start_a = 1'b0;
      if (done_a) begin
        done_pulses++;
        done_at = j;
      end
    end
    check("midsweep_start_done_pulses", done_pulses, 1);
    check("midsweep_start_done_at", done_at, 32);
    check("midsweep_start_idle", busy_a, 0);

    // Start held high: restart on the first edge spent in IDLE.
    start_a = 1'b1;
    @(posedge clk);
    #1;
    k = 0;
    while (!done_a && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("held_start_first_done", k, 32);
    @(posedge clk);
    #1;
    check("held_start_pass_set", pass_a, 1);
    check("held_start_idle_cycle", busy_a, 0);
    @(posedge clk);
    #1;
    check("held_start_restart_busy", busy_a, 1);
    check("held_start_pass_cleared", pass_a, 0);
    start_a = 1'b0;
    k = 0;
    while (!done_a && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("held_start_second_done", k, 32);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of SETTLE for input 4.
    f5 = STOP ? 8'hE8 : (8'hE8 ^ 8'h08);
    @(negedge clk);
    func_a = f5; exp_a = 8'hE8; start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    k = 0;
    while (dut_in_a != 3'd4 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("reach_dut_in_4", k, 16);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dut_in", dut_in_a, 0);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_table", tbl_a, 0);
    check("async_rst_fail", fcnt_a, 0);
    check("async_rst_first", first_a, 0);
    check("async_rst_pass_done", {pass_a, done_a}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_busy = 0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      if (busy_a !== 1'b0 || dut_in_a !== 3'd0) idle_busy++;
    end
    check("post_rst_stays_idle", idle_busy, 0);

    // Sweep after reset behaves normally.
    run_sweep(1'b0, 8'hE8, 8'hE8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer for the 3-input boolean function units (boolean2 and siblings).
- Drives every input combination in ascending order, waits a settle interval and captures the unit's output.
- Assembles the captured truth table and compares it bit-by-bit against an expected table.
- Replaces hand-written exhaustive stimulus in lab benches and can run on the FPGA.

Parameters:
- N_IN, 3, number of boolean-function inputs; table depth = 2**N_IN.
- SETTLE_CYCLES, 2, cycles `dut_in` is held stable before sampling, legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE.
- expected  input  2**N_IN  golden truth table; bit i = expected y for input value i; sampled every SAMPLE cycle, hold stable during sweep.
- dut_in  output  N_IN  drives the function unit's inputs; MSB = a, LSB = c for N_IN=3.
- dut_y  input  1  function unit output.
- busy  output  1  high in every non-IDLE state.
- done  output  1  one-cycle pulse when the sweep ends.
- table_out  output  2**N_IN  captured truth table; bit i = `dut_y` sampled for input i.
- fail_count  output  N_IN+1  number of mismatching entries.
- first_fail_idx  output  N_IN  lowest mismatching input value; meaningful only when fail_count != 0.
- pass  output  1  registered at end of sweep: 1 iff fail_count == 0; held until next accepted start.

Behaviour:
- Reset (async, rst=1): state IDLE; dut_in, busy, done, table_out, fail_count, first_fail_idx and pass all 0; counters 0.
- Deassertion is sampled on clk.
- All outputs are registered.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 at an edge -> DRIVE. On that edge: idx=0, dut_in=0, table_out=0, fail_count=0, first_fail_idx=0, pass=0.
- DRIVE: 1 cycle, dut_in=idx. Next state is SETTLE with settle counter = SETTLE_CYCLES; if SETTLE_CYCLES=0 go straight to SAMPLE.
- SETTLE: decrement counter each cycle; leave to SAMPLE after SETTLE_CYCLES cycles.
- SAMPLE: 1 cycle. table_out[idx] <= dut_y.
  - If dut_y != expected[idx]: fail_count increments, saturating at 2**N_IN.
  - If this is the first mismatch (fail_count was 0): first_fail_idx <= idx.
  - If idx == 2**N_IN-1 -> DONE; else idx+1 and -> DRIVE. No wrap of idx.
- DONE: 1 cycle, done=1, pass <= (final fail_count == 0), then -> IDLE. busy is high in DONE and low in IDLE.
- Per-vector occupancy is 2+SETTLE_CYCLES cycles.
- If start is sampled at edge k, DONE is entered on edge k+(2+SETTLE_CYCLES)*2**N_IN (k+32 for defaults); done is high for the following cycle.
- start while busy: ignored, with no restart or queuing.
- start held high: a new sweep is accepted on the first edge the block is in IDLE, i.e. the edge after DONE.
- dut_in holds its last value (2**N_IN-1) after a sweep until the next start.
- table_out, fail_count and first_fail_idx hold until the next accepted start.
- rst mid-sweep: immediate return to reset values and the partial table is discarded; a start is required to begin again.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE transitions directly to DONE, not DRIVE. fail_count is then 1, first_fail_idx = the failing idx, and table_out bits above idx remain 0. pass=0.
- Undefined: full sweep always; fail_count counts all mismatches.

Test Plan:
1. Majority function, expected=8'hE8, DUT correct, defaults -> dut_in steps 0..7, each held 4 cycles; done 32 cycles after the start edge; table_out=8'hE8, fail_count=0, pass=1.
2. expected=8'hE8, DUT output forced inverted at inputs 3 and 5 -> table_out=8'hC0, fail_count=2, first_fail_idx=3, pass=0. With SWEEP_STOP_ON_FAIL_EN: done 16 cycles after start, fail_count=1, table_out=8'h00, first_fail_idx=3.
3. SETTLE_CYCLES=0, XOR3 unit, expected=8'h96 -> done 16 cycles after start, table_out=8'h96, pass=1.
4. Pulse start again at cycle 10 of a sweep -> ignored; exactly one done pulse at cycle 32. Then hold start high -> second sweep starts on the edge after DONE, and pass clears to 0 on that edge.
5. Assert rst asynchronously while dut_in=4 (mid-SETTLE) -> all outputs 0 immediately, before the next clk edge; after release, busy stays 0 until start.
6. All-zero unit, expected=8'hFF -> fail_count=8, saturated at the maximum and no wrap; first_fail_idx=0, pass=0.
